// File: rtl/apb_xfer_sched.sv
// Write/read command scheduler for the AXI-to-APB bridge: round-robin grant,
// APB SETUP/ACCESS sequencing with PREADY timeout, one response per command.
module apb_xfer_sched #(
  parameter int unsigned ID_NUM      = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                            ACLK_i,
  input  logic                            ARESET_i,
  input  logic                            wr_vld_i,
  output logic                            wr_rdy_o,
  input  logic [ID_NUM+ADDR_W+DATA_W-1:0] wr_payload_i,
  input  logic                            rd_vld_i,
  output logic                            rd_rdy_o,
  input  logic [ID_NUM+ADDR_W-1:0]        rd_payload_i,
  output logic                            bresp_vld_o,
  input  logic                            bresp_rdy_i,
  output logic [ID_NUM:0]                 bresp_o,
  output logic                            rresp_vld_o,
  input  logic                            rresp_rdy_i,
  output logic [ID_NUM+DATA_W:0]          rresp_o,
  output logic                            PSEL_o,
  output logic                            PENABLE_o,
  output logic                            PWRITE_o,
  output logic [ADDR_W-1:0]               PADDR_o,
  output logic [DATA_W-1:0]               PWDATA_o,
  input  logic [DATA_W-1:0]               PRDATA_i,
  input  logic                            PREADY_i,
  input  logic                            PSLVERR_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_wr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                lat_write_q;
  logic [ID_NUM-1:0]   lat_id_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic                rsp_slverr_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic                grant_wr, grant_rd;
  logic                timeout_hit;
  logic                resp_accept;
  logic                apb_active;

  logic [ID_NUM-1:0]   wr_id, rd_id;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data;

  assign {wr_id, wr_addr, wr_data} = wr_payload_i;
  assign {rd_id, rd_addr}          = rd_payload_i;

  assign timeout_hit = (TIMEOUT_CYC != 0) && !PREADY_i && (cnt_q == CNT_LAST);
  assign resp_accept = lat_write_q ? bresp_rdy_i : rresp_rdy_i;

  // Grants are suppressed while reset is asserted so no pop escapes during reset.
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ARESET_i) begin
          grant_wr = wr_vld_i && (ptr_wr_q || !rd_vld_i);
          grant_rd = rd_vld_i && !grant_wr;
          if (grant_wr || grant_rd) state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (PREADY_i || timeout_hit) state_d = S_RESP;
      S_RESP:   if (resp_accept) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q      <= S_IDLE;
      ptr_wr_q     <= 1'b1;
      cnt_q        <= '0;
      lat_write_q  <= 1'b0;
      lat_id_q     <= '0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q <= state_d;

      if (grant_wr || grant_rd) begin
        ptr_wr_q    <= grant_rd;
        lat_write_q <= grant_wr;
        if (grant_wr) begin
          lat_id_q    <= wr_id;
          lat_addr_q  <= wr_addr & WORD_MASK;
          lat_wdata_q <= wr_data;
        end else begin
          lat_id_q    <= rd_id;
          lat_addr_q  <= rd_addr & WORD_MASK;
          lat_wdata_q <= '0;
        end
      end

      if (state_q == S_ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
        if (PREADY_i) begin
          rsp_slverr_q <= PSLVERR_i;
          rsp_rdata_q  <= lat_write_q ? '0 : PRDATA_i;
        end else if (timeout_hit) begin
          rsp_slverr_q <= 1'b1;
          rsp_rdata_q  <= '0;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign apb_active = (state_q == S_SETUP) || (state_q == S_ACCESS);

  assign wr_rdy_o  = grant_wr;
  assign rd_rdy_o  = grant_rd;

  assign PSEL_o    = apb_active;
  assign PENABLE_o = (state_q == S_ACCESS);
  assign PWRITE_o  = apb_active && lat_write_q;
  assign PADDR_o   = apb_active ? lat_addr_q  : '0;
  assign PWDATA_o  = apb_active ? lat_wdata_q : '0;

  assign bresp_vld_o = (state_q == S_RESP) &&  lat_write_q;
  assign rresp_vld_o = (state_q == S_RESP) && !lat_write_q;
  assign bresp_o     = bresp_vld_o ? {lat_id_q, rsp_slverr_q} : '0;
  assign rresp_o     = rresp_vld_o ? {lat_id_q, rsp_rdata_q, rsp_slverr_q} : '0;

endmodule

// File: tb/tb_apb_xfer_sched.sv
// Bench for apb_xfer_sched: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level scoreboard.
module tb_apb_xfer_sched;

  localparam int TMO = 16;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        wr_vld = 1'b0, rd_vld = 1'b0;
  logic [47:0] wr_payload = '0;
  logic [15:0] rd_payload = '0;
  logic        bresp_rdy = 1'b0, rresp_rdy = 1'b0;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  logic        wr_rdy_o, rd_rdy_o, bresp_vld_o, rresp_vld_o;
  logic [4:0]  bresp_o;
  logic [36:0] rresp_o;
  logic        PSEL_o, PENABLE_o, PWRITE_o;
  logic [11:0] PADDR_o;
  logic [31:0] PWDATA_o;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  apb_xfer_sched #(
    .ID_NUM(4), .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(TMO)
  ) dut (
    .ACLK_i(ACLK), .ARESET_i(ARESET),
    .wr_vld_i(wr_vld), .wr_rdy_o(wr_rdy_o), .wr_payload_i(wr_payload),
    .rd_vld_i(rd_vld), .rd_rdy_o(rd_rdy_o), .rd_payload_i(rd_payload),
    .bresp_vld_o(bresp_vld_o), .bresp_rdy_i(bresp_rdy), .bresp_o(bresp_o),
    .rresp_vld_o(rresp_vld_o), .rresp_rdy_i(rresp_rdy), .rresp_o(rresp_o),
    .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
    .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
    .PRDATA_i(PRDATA), .PREADY_i(PREADY), .PSLVERR_i(PSLVERR)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {wr_rdy_o, rd_rdy_o, bresp_vld_o, rresp_vld_o,
                         PSEL_o, PENABLE_o, PWRITE_o, bresp_o}, 64'h0);
    chk({name, "_rresp"}, rresp_o, 64'h0);
    chk({name, "_apb"}, {PADDR_o, PWDATA_o}, 64'h0);
  endtask

  // Reset with both requesters valid, so any pop during reset is visible.
  task automatic do_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b1; wr_vld = 1'b1; rd_vld = 1'b1; PREADY = 1'b0;
    bresp_rdy = 1'b1; rresp_rdy = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK); chk_all_zero("rst_a");
    @(negedge ACLK); chk_all_zero("rst_b");
    @(posedge ACLK); #1;
    ARESET = 1'b0; wr_vld = 1'b0; rd_vld = 1'b0;
    bresp_rdy = 1'b0; rresp_rdy = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    bit          pslverr;
    int          stall;
    int          exp_acc;
    logic [11:0] exp_paddr;
    logic [4:0]  exp_b;
    logic [36:0] exp_r;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int n, input vec_t v);
    int  j;
    bit  done;
    string t;
    t = $sformatf("v%0d", n);
    @(posedge ACLK); #1;
    wr_vld = v.wr; rd_vld = !v.wr;
    wr_payload = {v.id, v.addr, v.wdata}; rd_payload = {v.id, v.addr};
    PREADY = 1'b0; bresp_rdy = 1'b0; rresp_rdy = 1'b0;
    @(negedge ACLK);
    chk({t, "_pop"}, {wr_rdy_o, rd_rdy_o, PSEL_o}, {v.wr, !v.wr, 1'b0});
    @(posedge ACLK); #1;
    wr_vld = 1'b0; rd_vld = 1'b0;
    PRDATA = v.prdata; PSLVERR = v.pslverr;
    @(negedge ACLK);
    chk({t, "_setup"}, {PSEL_o, PENABLE_o, PWRITE_o, wr_rdy_o, rd_rdy_o},
        {1'b1, 1'b0, v.wr, 1'b0, 1'b0});
    chk({t, "_paddr"}, PADDR_o, v.exp_paddr);
    chk({t, "_pwdata"}, PWDATA_o, v.wr ? v.wdata : 32'h0);
    j = 0; done = 1'b0;
    while (!done && j < 40) begin
      j++;
      @(posedge ACLK); #1;
      PREADY = (j == v.waits + 1);
      @(negedge ACLK);
      if (PSEL_o !== 1'b1 || PENABLE_o !== 1'b1) begin
        chk({t, "_access_held"}, {PSEL_o, PENABLE_o}, 2'b11);
        done = 1'b1;
      end
      if (PREADY || j == TMO) done = 1'b1;
    end
    chk({t, "_access_len"}, j, v.exp_acc);
    for (int k = 0; k <= v.stall; k++) begin
      @(posedge ACLK); #1;
      PREADY = 1'b0; wr_vld = 1'b1; rd_vld = 1'b1;
      bresp_rdy = v.wr && (k == v.stall);
      rresp_rdy = !v.wr && (k == v.stall);
      @(negedge ACLK);
      chk({t, "_resp_ctl"}, {PSEL_o, PENABLE_o, wr_rdy_o, rd_rdy_o, bresp_vld_o, rresp_vld_o},
          {4'b0000, v.wr, !v.wr});
      if (v.wr) chk({t, "_bresp"}, bresp_o, v.exp_b);
      else      chk({t, "_rresp"}, rresp_o, v.exp_r);
    end
    @(posedge ACLK); #1;
    wr_vld = 1'b0; rd_vld = 1'b0; bresp_rdy = 1'b0; rresp_rdy = 1'b0;
    @(negedge ACLK);
    chk({t, "_idle"}, {PSEL_o, bresp_vld_o, rresp_vld_o, wr_rdy_o, rd_rdy_o}, 5'b0);
  endtask

  // Scoreboard state for the randomized run
  bit          m_ptr_wr;
  int          m_phase;          // 0 idle, 1 setup due, 2 access, 3 response
  bit          c_wr;
  logic [3:0]  c_id;
  logic [11:0] c_addr;
  logic [31:0] c_wdata;
  int          w_plan, acc_n;
  bit          e_slverr;
  logic [31:0] e_rdata;

  task automatic rand_phase(input int ncyc);
    logic [47:0] wq_head;
    logic [15:0] rq_head;
    bit n_wr_vld, n_rd_vld, n_brdy, n_rrdy, n_pready, n_pslverr;
    logic [31:0] n_prdata;
    bit exp_gw, exp_gr;
    int r;
    m_ptr_wr = 1'b1; m_phase = 0;
    wq_head = {4'($urandom), 12'($urandom), 32'($urandom)};
    rq_head = {4'($urandom), 12'($urandom)};
    n_wr_vld = 0; n_rd_vld = 0; n_brdy = 0; n_rrdy = 0;
    n_pready = 0; n_pslverr = 0; n_prdata = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge ACLK); #1;
      wr_vld = n_wr_vld; rd_vld = n_rd_vld;
      wr_payload = wq_head; rd_payload = rq_head;
      bresp_rdy = n_brdy; rresp_rdy = n_rrdy;
      PREADY = n_pready; PSLVERR = n_pslverr; PRDATA = n_prdata;
      @(negedge ACLK);
      if (PENABLE_o && !PSEL_o) chk("rnd_penable_psel", {PENABLE_o, PSEL_o}, 2'b11);
      if (bresp_vld_o && rresp_vld_o) chk("rnd_resp_excl", {bresp_vld_o, rresp_vld_o}, 2'b10);
      n_pready = 1'b0;
      case (m_phase)
        0: begin
          chk("rnd_idle_out", {PSEL_o, bresp_vld_o, rresp_vld_o}, 3'b0);
          exp_gw = wr_vld && (m_ptr_wr || !rd_vld);
          exp_gr = rd_vld && !exp_gw;
          chk("rnd_grant", {wr_rdy_o, rd_rdy_o}, {exp_gw, exp_gr});
          if (exp_gw) begin
            c_wr = 1'b1; {c_id, c_addr, c_wdata} = wr_payload;
            m_ptr_wr = 1'b0; m_phase = 1;
            wq_head = {4'($urandom), 12'($urandom), 32'($urandom)};
          end else if (exp_gr) begin
            c_wr = 1'b0; {c_id, c_addr} = rd_payload; c_wdata = '0;
            m_ptr_wr = 1'b1; m_phase = 1;
            rq_head = {4'($urandom), 12'($urandom)};
          end
        end
        1: begin
          chk("rnd_setup", {PSEL_o, PENABLE_o, PWRITE_o, wr_rdy_o, rd_rdy_o},
              {1'b1, 1'b0, c_wr, 1'b0, 1'b0});
          chk("rnd_paddr", PADDR_o, {c_addr[11:2], 2'b00});
          chk("rnd_pwdata", PWDATA_o, c_wdata);
          r = $urandom_range(0, 15);
          w_plan = (r < 11) ? (r % 4) : ((r < 13) ? TMO - 1 : 40);
          acc_n = 0; m_phase = 2;
          n_pready = (w_plan == 0);
        end
        2: begin
          chk("rnd_access", {PSEL_o, PENABLE_o, wr_rdy_o, rd_rdy_o}, 4'b1100);
          acc_n++;
          if (PREADY) begin
            chk("rnd_acc_len", acc_n, w_plan + 1);
            e_slverr = PSLVERR; e_rdata = c_wr ? 32'h0 : PRDATA; m_phase = 3;
          end else if (acc_n == TMO) begin
            e_slverr = 1'b1; e_rdata = 32'h0; m_phase = 3;
          end else begin
            n_pready = (acc_n == w_plan);
          end
        end
        default: begin
          chk("rnd_resp_ctl", {PSEL_o, PENABLE_o, wr_rdy_o, rd_rdy_o, bresp_vld_o, rresp_vld_o},
              {4'b0000, c_wr, !c_wr});
          if (c_wr) chk("rnd_bresp", bresp_o, {c_id, e_slverr});
          else      chk("rnd_rresp", rresp_o, {c_id, e_rdata, e_slverr});
          if (c_wr ? bresp_rdy : rresp_rdy) m_phase = 0;
        end
      endcase
      n_wr_vld = ($urandom_range(0, 9) < 6);
      n_rd_vld = ($urandom_range(0, 9) < 6);
      n_brdy = ($urandom_range(0, 3) != 0);
      n_rrdy = ($urandom_range(0, 3) != 0);
      n_pslverr = ($urandom_range(0, 3) == 0);
      n_prdata = $urandom;
    end
  endtask

  initial begin
    int grants;
    bit prev_pop;
    logic [3:0] exp_order;

    vecs[0] = '{1'b1, 4'h3, 12'h104, 32'hDEADBEEF, 0,  32'h0,        1'b0, 0,  1,  12'h104, {4'h3, 1'b0}, 37'h0};
    vecs[1] = '{1'b0, 4'h5, 12'h2A7, 32'h0,        3,  32'h12345678, 1'b1, 0,  4,  12'h2A4, 5'h0, {4'h5, 32'h12345678, 1'b1}};
    vecs[2] = '{1'b1, 4'hA, 12'hFFF, 32'h0,        20, 32'h55AA55AA, 1'b0, 0,  16, 12'hFFC, {4'hA, 1'b1}, 37'h0};
    vecs[3] = '{1'b0, 4'hC, 12'h010, 32'h0,        15, 32'hAAAA5555, 1'b0, 1,  16, 12'h010, 5'h0, {4'hC, 32'hAAAA5555, 1'b0}};
    vecs[4] = '{1'b0, 4'h7, 12'h333, 32'h0,        30, 32'hFFFFFFFF, 1'b0, 0,  16, 12'h330, 5'h0, {4'h7, 32'h0, 1'b1}};
    vecs[5] = '{1'b0, 4'h1, 12'h008, 32'h0,        0,  32'hCAFEF00D, 1'b0, 10, 1,  12'h008, 5'h0, {4'h1, 32'hCAFEF00D, 1'b0}};
    vecs[6] = '{1'b1, 4'hF, 12'h7FE, 32'h01234567, 2,  32'h0,        1'b1, 3,  3,  12'h7FC, {4'hF, 1'b1}, 37'h0};
    vecs[7] = '{1'b0, 4'h0, 12'h001, 32'h0,        1,  32'h00000001, 1'b0, 0,  2,  12'h000, 5'h0, {4'h0, 32'h1, 1'b0}};

    do_reset();
    for (int n = 0; n < 8; n++) run_vec(n, vecs[n]);

    // Both requesters held: round-robin must alternate starting with write.
    do_reset();
    @(posedge ACLK); #1;
    wr_vld = 1'b1; rd_vld = 1'b1; PREADY = 1'b1; bresp_rdy = 1'b1; rresp_rdy = 1'b1;
    wr_payload = {4'h2, 12'h040, 32'h11112222}; rd_payload = {4'h9, 12'h080};
    exp_order = 4'b0101;  // bit i = 1 means grant i goes to write
    grants = 0; prev_pop = 1'b0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge ACLK);
      if (wr_rdy_o || rd_rdy_o) begin
        chk($sformatf("rr_grant%0d", grants), {wr_rdy_o, rd_rdy_o},
            {exp_order[grants], !exp_order[grants]});
        chk("rr_single_cycle_pop", prev_pop, 1'b0);
        grants++;
        prev_pop = 1'b1;
      end else begin
        prev_pop = 1'b0;
      end
    end
    chk("rr_grant_count", grants, 4);

    // Reset during ACCESS: outputs clear, pointer returns to write-first.
    do_reset();
    @(posedge ACLK); #1;
    wr_vld = 1'b1; rd_vld = 1'b0; PREADY = 1'b0;
    wr_payload = {4'h6, 12'h0C4, 32'hA5A5A5A5};
    @(negedge ACLK); chk("rstacc_pop", wr_rdy_o, 1'b1);
    @(posedge ACLK); #1; wr_vld = 1'b0;
    @(negedge ACLK); chk("rstacc_setup", {PSEL_o, PENABLE_o}, 2'b10);
    @(posedge ACLK); #1;
    @(negedge ACLK); chk("rstacc_access", {PSEL_o, PENABLE_o}, 2'b11);
    @(posedge ACLK); #1; ARESET = 1'b1;
    @(negedge ACLK); chk("rstacc_sync", {PSEL_o, PENABLE_o}, 2'b11);
    @(posedge ACLK); #1;
    @(negedge ACLK); chk_all_zero("rstacc_clear");
    @(posedge ACLK); #1;
    ARESET = 1'b0; wr_vld = 1'b1; rd_vld = 1'b1;
    @(negedge ACLK); chk("rstacc_first_grant", {wr_rdy_o, rd_rdy_o}, 2'b10);
    @(posedge ACLK); #1; wr_vld = 1'b0; rd_vld = 1'b0;

    do_reset();
    rand_phase(2500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
